// File: rtl/mdu_ctrl_if.sv
// Handshake/operand bundle between the E stage and the multiply/divide sequencer.
// The slave modport is the MDU side; the master modport is the pipeline side.
interface mdu_ctrl_if;
    logic [2:0]  MDOp_E;
    logic        Valid_E;
    logic [1:0]  RdSel_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        IsMD_D;
    logic        Start;
    logic        Busy;
    logic        MDStall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOut_E;

    modport slave (
        input  MDOp_E, Valid_E, RdSel_E, A_E, B_E, IsMD_D,
        output Start, Busy, MDStall, HI, LO, MDOut_E
    );

    modport master (
        output MDOp_E, Valid_E, RdSel_E, A_E, B_E, IsMD_D,
        input  Start, Busy, MDStall, HI, LO, MDOut_E
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: computes the result at issue, then holds it in
// PendHI/PendLO while a busy counter models the fixed unit latency.
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_ctrl_if.slave   md
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        op_valid;
    logic        is_mul, is_div, is_mthi, is_mtlo;
    logic        start;
    logic [63:0] mul_a, mul_b, product;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag, quot, rem;

    assign op_valid = md.Valid_E && (state_q == S_IDLE);
    assign is_mul   = (md.MDOp_E == 3'd1) || (md.MDOp_E == 3'd2);
    assign is_div   = (md.MDOp_E == 3'd3) || (md.MDOp_E == 3'd4);
    assign is_mthi  = md.MDOp_E == 3'd5;
    assign is_mtlo  = md.MDOp_E == 3'd6;
    assign start    = op_valid && (is_mul || is_div);

    // Signed ops work on magnitudes; signs are restored after the unsigned divide.
    always_comb begin
        mul_a = (md.MDOp_E == 3'd1) ? {{32{md.A_E[31]}}, md.A_E} : {32'd0, md.A_E};
        mul_b = (md.MDOp_E == 3'd1) ? {{32{md.B_E[31]}}, md.B_E} : {32'd0, md.B_E};
        product = mul_a * mul_b;

        a_neg  = (md.MDOp_E == 3'd3) && md.A_E[31];
        b_neg  = (md.MDOp_E == 3'd3) && md.B_E[31];
        a_mag  = a_neg ? (~md.A_E + 32'd1) : md.A_E;
        b_mag  = b_neg ? (~md.B_E + 32'd1) : md.B_E;
        b_safe = (b_mag == '0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    if (is_mul) begin
                        cnt_d     = 4'(MULT_CYCLES);
                        pend_hi_d = product[63:32];
                        pend_lo_d = product[31:0];
                        pend_wr_d = 1'b1;
                    end else begin
                        cnt_d     = 4'(DIV_CYCLES);
                        pend_hi_d = rem;
                        pend_lo_d = quot;
                        pend_wr_d = (md.B_E != '0);
                    end
                end else if (op_valid && is_mthi) begin
                    hi_d = md.A_E;
                end else if (op_valid && is_mtlo) begin
                    lo_d = md.A_E;
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    always_comb begin
        md.Start   = start;
        md.Busy    = (state_q == S_RUN);
        md.MDStall = md.IsMD_D && (start || (state_q == S_RUN));
        md.HI      = hi_q;
        md.LO      = lo_q;
        case (md.RdSel_E)
            2'd1:    md.MDOut_E = hi_q;
            2'd2:    md.MDOut_E = lo_q;
            default: md.MDOut_E = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mdu_ctrl_if bus();

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.MDOp_E  = op;
    bus.Valid_E = 1'b1;
    bus.A_E     = a;
    bus.B_E     = b;
  endtask

  task automatic clear_op;
    bus.MDOp_E  = 3'd0;
    bus.Valid_E = 1'b0;
    bus.A_E     = '0;
    bus.B_E     = '0;
  endtask

  task automatic issue_and_wait(input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, output int n);
    drive(op, a, b);
    step;
    clear_op;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step;
    end
  endtask

  task automatic test_reset;
    clear_op;
    bus.RdSel_E = 2'd1;
    bus.IsMD_D  = 1'b1;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({bus.Busy, bus.Start, bus.MDStall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {bus.Busy, bus.Start, bus.MDStall});
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.MDOut_E !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%h expected 0/0/0", bus.HI, bus.LO, bus.MDOut_E);
    end
    rst_n = 1'b1;
    bus.RdSel_E = 2'd0;
    bus.IsMD_D  = 1'b0;
    step;
  endtask

  task automatic test_mult;
    int n;
    drive(3'd1, 32'hFFFF_FFFE, 32'd3);
    bus.IsMD_D = 1'b1;
    #1;
    checks++;
    if ({bus.Start, bus.MDStall, bus.Busy} !== 3'b110) begin
      errors++;
      $display("FAIL mult_issue: got %b expected 110", {bus.Start, bus.MDStall, bus.Busy});
    end
    step;
    clear_op;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      checks++;
      if (bus.MDStall !== 1'b1) begin
        errors++;
        $display("FAIL mult_stall: got %b expected 1 at busy cycle %0d", bus.MDStall, n + 1);
      end
      n++;
      step;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_busy_len: got %0d expected 5", n);
    end
    checks++;
    if (bus.MDStall !== 1'b0) begin
      errors++;
      $display("FAIL mult_stall_release: got %b expected 0", bus.MDStall);
    end
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: got %h_%h expected ffffffff_fffffffa", bus.HI, bus.LO);
    end
    bus.IsMD_D = 1'b0;
    step;
    bus.RdSel_E = 2'd2;
    #1;
    checks++;
    if (bus.MDOut_E !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_mflo: got %h expected fffffffa", bus.MDOut_E);
    end
    bus.RdSel_E = 2'd0;
  endtask

  task automatic test_multu;
    int n;
    bus.IsMD_D = 1'b0;
    drive(3'd2, 32'hFFFF_FFFE, 32'd3);
    step;
    clear_op;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      checks++;
      if (bus.MDStall !== 1'b0) begin
        errors++;
        $display("FAIL multu_alu_flow: got %b expected 0", bus.MDStall);
      end
      n++;
      step;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL multu_busy_len: got %0d expected 5", n);
    end
    checks++;
    if (bus.HI !== 32'h0000_0002 || bus.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu_result: got %h_%h expected 00000002_fffffffa", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div;
    int n;
    issue_and_wait(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL div_busy_len: got %0d expected 10", n);
    end
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg: got %h_%h expected ffffffff_fffffffd", bus.HI, bus.LO);
    end
    issue_and_wait(3'd4, 32'd7, 32'd2, n);
    checks++;
    if (n !== 10 || bus.HI !== 32'd1 || bus.LO !== 32'd3) begin
      errors++;
      $display("FAIL divu_7_2: got n=%0d %h_%h expected n=10 00000001_00000003", n, bus.HI, bus.LO);
    end
    issue_and_wait(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow: got %h_%h expected 00000000_80000000", bus.HI, bus.LO);
    end
  endtask

  task automatic test_divzero;
    int n;
    drive(3'd5, 32'h11, 32'd0);
    step;
    drive(3'd6, 32'h22, 32'd0);
    step;
    clear_op;
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mt_preload: got %h_%h busy=%b expected 00000011_00000022 busy=0", bus.HI, bus.LO, bus.Busy);
    end
    issue_and_wait(3'd3, 32'd5, 32'd0, n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL divzero_busy_len: got %0d expected 10", n);
    end
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      errors++;
      $display("FAIL divzero_hold: got %h_%h expected 00000011_00000022", bus.HI, bus.LO);
    end
    issue_and_wait(3'd4, 32'd9, 32'd0, n);
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      errors++;
      $display("FAIL divuzero_hold: got %h_%h expected 00000011_00000022", bus.HI, bus.LO);
    end
  endtask

  task automatic test_mt_mf;
    drive(3'd6, 32'h1234, 32'd0);
    #1;
    checks++;
    if (bus.Start !== 1'b0 || bus.MDStall !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_no_start: got %b%b expected 00", bus.Start, bus.MDStall);
    end
    step;
    clear_op;
    bus.RdSel_E = 2'd2;
    #1;
    checks++;
    if (bus.MDOut_E !== 32'h1234 || bus.Busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_mflo: got %h busy=%b expected 00001234 busy=0", bus.MDOut_E, bus.Busy);
    end
    bus.RdSel_E = 2'd1;
    #1;
    checks++;
    if (bus.MDOut_E !== 32'h11) begin
      errors++;
      $display("FAIL mfhi: got %h expected 00000011", bus.MDOut_E);
    end
    bus.RdSel_E = 2'd3;
    #1;
    checks++;
    if (bus.MDOut_E !== 32'd0) begin
      errors++;
      $display("FAIL rdsel3: got %h expected 00000000", bus.MDOut_E);
    end
    bus.RdSel_E = 2'd0;
    drive(3'd7, 32'hDEAD, 32'd1);
    #1;
    checks++;
    if (bus.Start !== 1'b0) begin
      errors++;
      $display("FAIL op7_start: got %b expected 0", bus.Start);
    end
    step;
    clear_op;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'h11 || bus.LO !== 32'h1234) begin
      errors++;
      $display("FAIL op7_none: got busy=%b %h_%h expected busy=0 00000011_00001234", bus.Busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    drive(3'd1, 32'd6, 32'd7);
    step;
    drive(3'd1, 32'd3, 32'd3);
    #1;
    checks++;
    if (bus.Start !== 1'b0) begin
      errors++;
      $display("FAIL inject_start: got %b expected 0", bus.Start);
    end
    step;
    drive(3'd5, 32'hDEAD, 32'd0);
    step;
    clear_op;
    n = 0;
    while (bus.Busy === 1'b1 && n < 40) begin
      n++;
      step;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL inject_len: got %0d expected 3 remaining busy cycles", n);
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
      errors++;
      $display("FAIL inject_result: got %h_%h expected 00000000_0000002a", bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_mid_div;
    drive(3'd5, 32'h55, 32'd0);
    step;
    drive(3'd3, 32'd100, 32'd7);
    step;
    clear_op;
    step;
    step;
    bus.IsMD_D = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.MDStall !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b stall=%b %h_%h expected 0 0 0_0",
               bus.Busy, bus.MDStall, bus.HI, bus.LO);
    end
    #2;
    rst_n = 1'b1;
    bus.IsMD_D = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      step;
      checks++;
      if (bus.Busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
        errors++;
        $display("FAIL post_reset_quiet: got busy=%b %h_%h expected 0 0_0 at cycle %0d",
                 bus.Busy, bus.HI, bus.LO, i);
      end
    end
  endtask

  initial begin
    clear_op;
    bus.RdSel_E = 2'd0;
    bus.IsMD_D  = 1'b0;
    test_reset;
    test_mult;
    test_multu;
    test_div;
    test_divzero;
    test_mt_mf;
    test_back_to_back;
    test_reset_mid_div;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
